multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the 64-bit RV64 datapath: PC/adder, program memory, register file, ALU, data memory and write-back mux.
- Decodes the latched instruction and drives pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src and the 4-bit ALU op, one phase per cycle.
- Waits on a data-memory ready handshake, with a timeout.
- Counts retired instructions and halts on an illegal opcode or a memory timeout.

Parameters:
- MEM_WAIT_MAX, 15: maximum MEM-state cycles without mem_ready before a fault (1..255).
- RET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  allows a new instruction fetch
- instruction  in  32  instruction word from program memory
- zero  in  1  ALU zero flag
- mem_ready  in  1  data memory completed the current read/write
- pc_write  out  1  PC loads PC+4
- ir_write  out  1  instruction register / decode fields load
- branch_taken  out  1  PC loads branch target
- mem_read  out  1  data memory read strobe
- mem_write  out  1  data memory write strobe
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back mux select: 1 = read data, 0 = ALU result
- alu_src  out  1  ALU operand B: 1 = immediate, 0 = rs2
- alu_op  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- state  out  3  current FSM state encoding
- illegal  out  1  sticky illegal-instruction flag
- fault  out  1  sticky memory-timeout flag
- retired  out  RET_W  count of completed instructions

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, retired=0, illegal=0, fault=0, wait counter=0, latched opcode/funct fields=0. Every strobe output is 0 and alu_op=0000 during and after reset until the FSM moves.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Outputs are Moore, decoded from state plus the latched fields. branch_taken is the only Mealy output (EXEC and beq and zero). Outputs not listed for a state are 0.
- IDLE: if run=1 go to FETCH, else stay.
- FETCH: pc_write=1, ir_write=1; latch opcode[6:0], funct3, funct7[5]; go to DECODE.
- DECODE: classify the latched fields. Legal instructions:
  - R-type 0110011 with funct3/funct7[5]: 000/0 ADD, 000/1 SUB, 111/0 AND, 110/0 OR
  - ld: 0000011, funct3 011
  - sd: 0100011, funct3 011
  - beq: 1100011, funct3 000
  - Anything else: set illegal=1, go to HALT. Legal: go to EXEC.
- EXEC:
  - R-type: alu_src=0, alu_op per function, go to WB.
  - ld/sd: alu_src=1, alu_op=ADD, clear wait counter, go to MEM.
  - beq: alu_src=0, alu_op=SUB, branch_taken=zero; retire; go to FETCH if run else IDLE.
- MEM: alu_src=1, alu_op=ADD held. mem_read=1 for ld, mem_write=1 for sd, held every MEM cycle until mem_ready.
  - mem_ready=1: ld goes to WB; sd retires and goes to FETCH/IDLE per run.
  - mem_ready=0: wait counter +1. When the counter reaches MEM_WAIT_MAX, set fault=1 and go to HALT. Strobes drop on entry to HALT.
- WB: reg_write=1, mem_to_reg=1 for ld and 0 for R-type; retire; go to FETCH if run else IDLE.
- HALT: all strobes 0. Stays until rst_n; run is ignored.
- Retire: retired increments by 1 on the transition out of WB, sd-MEM completion or beq-EXEC. It wraps modulo 2^RET_W with no flag.
- Instruction latency: R-type 4 cycles, beq 3, ld 5+w, sd 4+w, where w = MEM cycles with mem_ready=0.
- run is sampled only in IDLE and at retire. Deasserting run mid-instruction does not abort it.
- mem_ready outside MEM is ignored. mem_ready=1 on the same cycle the counter would hit MEM_WAIT_MAX: completion wins, no fault.
- Reset mid-MEM: strobes drop immediately (asynchronous); the in-flight instruction is not retired.

Test Plan:
- add (0x00B50533), run=1 from reset: FETCH/DECODE/EXEC/WB = states 1,2,3,5, alu_op=0010, reg_write=1 in WB with mem_to_reg=0; retired=1 after 4 cycles.
- ld (0x0005B503), mem_ready low 3 cycles then high: mem_read=1 for 4 MEM cycles, alu_src=1; WB has mem_to_reg=1, reg_write=1; retired increments after 8 cycles.
- beq (0x00B50463) with zero=1, then again with zero=0: branch_taken=1 in EXEC only for the first; alu_op=0110 both times; no pc_write in EXEC.
- Illegal word 0xFFFFFFFF: DECODE → HALT, illegal=1, all strobes 0; run toggling has no effect until rst_n.
- sd (0x00B53023) with MEM_WAIT_MAX=15, mem_ready held 0: mem_write=1 for 15 cycles, then fault=1, state=6, retired unchanged.
- ld in MEM with mem_read=1, rst_n pulsed low mid-cycle: mem_read drops without a clock edge, state=0, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64 control FSM: fetch/decode/exec/mem/wb sequencing, retire counter, illegal/timeout halt.
// Latency: R-type 4 cycles, beq 3, ld 5+w, sd 4+w (w = MEM cycles without mem_ready); strobes registered.
// Backpressure: MEM holds its strobe until mem_ready, faulting to HALT after MEM_WAIT_MAX idle cycles.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int RET_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [31:0]      instruction,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             branch_taken,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             fault,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ADD, C_SUB, C_AND, C_OR, C_LD, C_SD, C_BEQ, C_ILL
    } cls_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    // Instruction class from the latched opcode/funct fields.
    function automatic cls_t classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        cls_t c;
        c = C_ILL;
        case (op)
            7'b0110011: begin
                if      (f3 == 3'b000 && !f7) c = C_ADD;
                else if (f3 == 3'b000 &&  f7) c = C_SUB;
                else if (f3 == 3'b111 && !f7) c = C_AND;
                else if (f3 == 3'b110 && !f7) c = C_OR;
                else                          c = C_ILL;
            end
            7'b0000011: c = (f3 == 3'b011) ? C_LD  : C_ILL;
            7'b0100011: c = (f3 == 3'b011) ? C_SD  : C_ILL;
            7'b1100011: c = (f3 == 3'b000) ? C_BEQ : C_ILL;
            default:    c = C_ILL;
        endcase
        return c;
    endfunction

    // Moore strobe pattern for a state/class pair; anything not named stays 0.
    function automatic ctrl_t ctrl_for(input state_t s, input cls_t c);
        ctrl_t r;
        r = '0;
        case (s)
            S_FETCH: begin
                r.pc_write = 1'b1;
                r.ir_write = 1'b1;
            end
            S_EXEC: begin
                case (c)
                    C_ADD:       r.alu_op = OP_ADD;
                    C_SUB:       r.alu_op = OP_SUB;
                    C_AND:       r.alu_op = OP_AND;
                    C_OR:        r.alu_op = OP_OR;
                    C_LD, C_SD: begin
                        r.alu_src = 1'b1;
                        r.alu_op  = OP_ADD;
                    end
                    C_BEQ:       r.alu_op = OP_SUB;
                    default:     r.alu_op = 4'b0000;
                endcase
            end
            S_MEM: begin
                r.alu_src   = 1'b1;
                r.alu_op    = OP_ADD;
                r.mem_read  = (c == C_LD);
                r.mem_write = (c == C_SD);
            end
            S_WB: begin
                r.reg_write  = 1'b1;
                r.mem_to_reg = (c == C_LD);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [2:0]       funct3_q, funct3_d;
    logic             funct7b5_q, funct7b5_d;
    logic [7:0]       wait_q, wait_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             fault_q, fault_d;
    ctrl_t            ctrl_q, ctrl_d;
    cls_t             cls_q, cls_d;

    assign cls_q = classify(opcode_q, funct3_q, funct7b5_q);
    assign cls_d = classify(opcode_d, funct3_d, funct7b5_d);

    // Next-state, field latch, wait counter, retire and sticky-flag logic.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        wait_d     = wait_q;
        retired_d  = retired_q;
        illegal_d  = illegal_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                opcode_d   = instruction[6:0];
                funct3_d   = instruction[14:12];
                funct7b5_d = instruction[30];
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                if (cls_q == C_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_LD, C_SD: begin
                        wait_d  = 8'd0;
                        state_d = S_MEM;
                    end
                    C_BEQ: begin
                        retired_d = retired_q + 1'b1;
                        state_d   = run ? S_FETCH : S_IDLE;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls_q == C_LD) begin
                        state_d = S_WB;
                    end else begin
                        retired_d = retired_q + 1'b1;
                        state_d   = run ? S_FETCH : S_IDLE;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                    // Completion on the final allowed cycle takes priority over the timeout.
                    if (wait_q + 8'd1 == WAIT_MAX) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_WB: begin
                retired_d = retired_q + 1'b1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        ctrl_d = ctrl_for(state_d, cls_d);
    end

    // All FSM state and registered strobes; async reset clears strobes without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opcode_q   <= 7'd0;
            funct3_q   <= 3'd0;
            funct7b5_q <= 1'b0;
            wait_q     <= 8'd0;
            retired_q  <= '0;
            illegal_q  <= 1'b0;
            fault_q    <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            wait_q     <= wait_d;
            retired_q  <= retired_d;
            illegal_q  <= illegal_d;
            fault_q    <= fault_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign pc_write     = ctrl_q.pc_write;
    assign ir_write     = ctrl_q.ir_write;
    assign mem_read     = ctrl_q.mem_read;
    assign mem_write    = ctrl_q.mem_write;
    assign reg_write    = ctrl_q.reg_write;
    assign mem_to_reg   = ctrl_q.mem_to_reg;
    assign alu_src      = ctrl_q.alu_src;
    assign alu_op       = ctrl_q.alu_op;
    // Branch decision follows the live zero flag while in EXEC.
    assign branch_taken = (state_q == S_EXEC) && (cls_q == C_BEQ) && zero;
    assign state        = state_q;
    assign illegal      = illegal_q;
    assign fault        = fault_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors queued and compared.
// Each step pushes the expectation, advances one clock, samples 1 time unit after the edge.
// Covers R-type, ld with wait states, beq taken/not-taken, sd timeout, illegal halt, async reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] instruction;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, branch_taken, mem_read, mem_write;
    logic        reg_write, mem_to_reg, alu_src;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic        illegal, fault;
    logic [31:0] retired;

    multicycle_ctrl #(.MEM_WAIT_MAX(15), .RET_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .instruction  (instruction),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .branch_taken (branch_taken),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .state        (state),
        .illegal      (illegal),
        .fault        (fault),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    // Strobe byte order: {pc_write, ir_write, branch_taken, mem_read, mem_write, reg_write, mem_to_reg, alu_src}
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] PWIW = 8'b1100_0000;
    localparam logic [7:0] BT   = 8'b0010_0000;
    localparam logic [7:0] MR   = 8'b0001_0000;
    localparam logic [7:0] MW   = 8'b0000_1000;
    localparam logic [7:0] RW   = 8'b0000_0100;
    localparam logic [7:0] M2R  = 8'b0000_0010;
    localparam logic [7:0] AS   = 8'b0000_0001;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                           MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

    typedef logic [48:0] vec_t;
    vec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t observed();
        return {state, pc_write, ir_write, branch_taken, mem_read, mem_write,
                reg_write, mem_to_reg, alu_src, alu_op, illegal, fault, retired};
    endfunction

    task automatic check(input string tag);
        vec_t e, o;
        e = exp_q.pop_front();
        o = observed();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Queue the expectation, then check without waiting for a clock.
    task automatic now(input logic [2:0] st, input logic [7:0] sb, input logic [3:0] op,
                       input logic ill, input logic flt, input logic [31:0] ret, input string tag);
        exp_q.push_back({st, sb, op, ill, flt, ret});
        check(tag);
    endtask

    // Queue the expectation, advance one clock, then check.
    task automatic cyc(input logic [2:0] st, input logic [7:0] sb, input logic [3:0] op,
                       input logic ill, input logic flt, input logic [31:0] ret, input string tag);
        exp_q.push_back({st, sb, op, ill, flt, ret});
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst_n       = 1'b0;
        run         = 1'b0;
        instruction = 32'h0;
        zero        = 1'b0;
        mem_ready   = 1'b0;
        #2;
        now(IDLE, NONE, 4'h0, 0, 0, 0, "reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(IDLE, NONE, 4'h0, 0, 0, 0, "idle_hold");

        // add x10,x10,x11
        instruction = 32'h00B50533;
        run = 1'b1;
        cyc(FETCH,  PWIW, 4'h0, 0, 0, 0, "add_fetch");
        run = 1'b0;
        cyc(DECODE, NONE, 4'h0, 0, 0, 0, "add_decode");
        cyc(EXEC,   NONE, 4'h2, 0, 0, 0, "add_exec");
        cyc(WB,     RW,   4'h0, 0, 0, 0, "add_wb");
        cyc(IDLE,   NONE, 4'h0, 0, 0, 1, "add_retire");

        // ld x10,0(x11) with three wait cycles
        instruction = 32'h0005B503;
        run = 1'b1;
        cyc(FETCH,  PWIW, 4'h0, 0, 0, 1, "ld_fetch");
        run = 1'b0;
        cyc(DECODE, NONE, 4'h0, 0, 0, 1, "ld_decode");
        cyc(EXEC,   AS,   4'h2, 0, 0, 1, "ld_exec");
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(MEM, MR | AS, 4'h2, 0, 0, 1, "ld_mem");
        mem_ready = 1'b1;
        cyc(WB,     RW | M2R, 4'h0, 0, 0, 1, "ld_wb");
        mem_ready = 1'b0;
        cyc(IDLE,   NONE, 4'h0, 0, 0, 2, "ld_retire");

        // beq taken
        instruction = 32'h00B50463;
        zero = 1'b1;
        run = 1'b1;
        cyc(FETCH,  PWIW, 4'h0, 0, 0, 2, "beq1_fetch");
        run = 1'b0;
        cyc(DECODE, NONE, 4'h0, 0, 0, 2, "beq1_decode");
        cyc(EXEC,   BT,   4'h6, 0, 0, 2, "beq1_exec");
        cyc(IDLE,   NONE, 4'h0, 0, 0, 3, "beq1_retire");

        // beq not taken; run held so retire goes straight to the next fetch (sd)
        zero = 1'b0;
        run = 1'b1;
        cyc(FETCH,  PWIW, 4'h0, 0, 0, 3, "beq2_fetch");
        cyc(DECODE, NONE, 4'h0, 0, 0, 3, "beq2_decode");
        cyc(EXEC,   NONE, 4'h6, 0, 0, 3, "beq2_exec");
        instruction = 32'h00B53023;
        cyc(FETCH,  PWIW, 4'h0, 0, 0, 4, "sd_fetch_b2b");
        run = 1'b0;

        // sd with mem_ready stuck low: 15 MEM cycles then fault
        cyc(DECODE, NONE, 4'h0, 0, 0, 4, "sd_decode");
        cyc(EXEC,   AS,   4'h2, 0, 0, 4, "sd_exec");
        for (int i = 0; i < 15; i++) cyc(MEM, MW | AS, 4'h2, 0, 0, 4, "sd_mem");
        cyc(HALT,   NONE, 4'h0, 0, 1, 4, "sd_timeout");
        run = 1'b1;
        cyc(HALT,   NONE, 4'h0, 0, 1, 4, "fault_sticky");

        // illegal instruction
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        now(IDLE, NONE, 4'h0, 0, 0, 0, "reset2");
        @(negedge clk);
        rst_n = 1'b1;
        instruction = 32'hFFFFFFFF;
        run = 1'b1;
        cyc(FETCH,  PWIW, 4'h0, 0, 0, 0, "ill_fetch");
        cyc(DECODE, NONE, 4'h0, 0, 0, 0, "ill_decode");
        cyc(HALT,   NONE, 4'h0, 1, 0, 0, "ill_halt");
        for (int i = 0; i < 3; i++) begin
            run = ~run;
            cyc(HALT, NONE, 4'h0, 1, 0, 0, "ill_run_toggle");
        end

        // sd completing on the last allowed cycle: no fault
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        instruction = 32'h00B53023;
        run = 1'b1;
        cyc(FETCH,  PWIW, 4'h0, 0, 0, 0, "sdb_fetch");
        run = 1'b0;
        cyc(DECODE, NONE, 4'h0, 0, 0, 0, "sdb_decode");
        cyc(EXEC,   AS,   4'h2, 0, 0, 0, "sdb_exec");
        for (int i = 0; i < 15; i++) cyc(MEM, MW | AS, 4'h2, 0, 0, 0, "sdb_mem");
        mem_ready = 1'b1;
        cyc(IDLE,   NONE, 4'h0, 0, 0, 1, "sdb_complete");
        mem_ready = 1'b0;

        // ld interrupted by reset while in MEM
        instruction = 32'h0005B503;
        run = 1'b1;
        cyc(FETCH,  PWIW, 4'h0, 0, 0, 1, "ldr_fetch");
        run = 1'b0;
        cyc(DECODE, NONE, 4'h0, 0, 0, 1, "ldr_decode");
        cyc(EXEC,   AS,   4'h2, 0, 0, 1, "ldr_exec");
        cyc(MEM,    MR | AS, 4'h2, 0, 0, 1, "ldr_mem");
        #2;
        rst_n = 1'b0;
        #1;
        now(IDLE, NONE, 4'h0, 0, 0, 0, "ldr_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc(IDLE, NONE, 4'h0, 0, 0, 0, "ldr_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
